// File: rtl/pipe_sel_decoder.sv
// Pipelined SEL_W-to-2**SEL_W select decoder (one-hot / thermometer / active-low one-hot)
// behind a 2-entry valid/ready skid buffer; 1-cycle latency, full throughput, lossless back-pressure.
module pipe_sel_decoder #(
    parameter int SEL_W      = 4,
    parameter int ERR_STICKY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [1:0]              in_mode,
    input  logic                    in_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [(1<<SEL_W)-1:0]   out_code,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    err
);

    localparam int OUT_W = 1 << SEL_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               push;
    logic               pop;

    logic [OUT_W-1:0]   new_code;
    logic               new_err;

    logic [OUT_W-1:0]   head_code;
    logic [SEL_W-1:0]   head_sel;
    logic               head_err;
    logic [OUT_W-1:0]   tail_code;
    logic [SEL_W-1:0]   tail_sel;
    logic               tail_err;

    logic               err_sticky;

    function automatic logic [OUT_W-1:0] decode(
        input logic [SEL_W-1:0] sel,
        input logic [1:0]       mode,
        input logic             en
    );
        logic [OUT_W-1:0] code;
        code = '0;
        for (int i = 0; i < OUT_W; i++) begin
            unique case (mode)
                2'b00:   code[i] = en & (SEL_W'(i) == sel);
                2'b01:   code[i] = en & (SEL_W'(i) <= sel);
                2'b10:   code[i] = ~en | (SEL_W'(i) != sel);
                default: code[i] = 1'b0;
            endcase
        end
        return code;
    endfunction

    assign new_code  = decode(in_sel, in_mode, in_en);
    assign new_err   = (in_mode == 2'b11);

    // in_ready depends only on occupancy and reset so upstream can never form a comb loop through it
    assign in_ready  = (state != S_TWO) & ~rst;
    assign out_valid = (state != S_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_EMPTY: begin
                if (push) state_nxt = S_ONE;
            end
            S_ONE: begin
                if (push && !pop)      state_nxt = S_TWO;
                else if (!push && pop) state_nxt = S_EMPTY;
            end
            S_TWO: begin
                if (pop) state_nxt = S_ONE;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Head always holds the oldest entry; tail is only occupied in S_TWO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_code <= '0;
            head_sel  <= '0;
            head_err  <= 1'b0;
            tail_code <= '0;
            tail_sel  <= '0;
            tail_err  <= 1'b0;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (push) begin
                        head_code <= new_code;
                        head_sel  <= in_sel;
                        head_err  <= new_err;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_code <= new_code;
                        head_sel  <= in_sel;
                        head_err  <= new_err;
                    end else if (push) begin
                        tail_code <= new_code;
                        tail_sel  <= in_sel;
                        tail_err  <= new_err;
                    end else if (pop) begin
                        head_code <= '0;
                        head_sel  <= '0;
                        head_err  <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        head_code <= tail_code;
                        head_sel  <= tail_sel;
                        head_err  <= tail_err;
                        tail_code <= '0;
                        tail_sel  <= '0;
                        tail_err  <= 1'b0;
                    end
                end
                default: begin
                    head_code <= '0;
                    head_sel  <= '0;
                    head_err  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (push && new_err) begin
            err_sticky <= 1'b1;
        end
    end

    assign out_code = head_code;
    assign out_sel  = head_sel;
    assign err      = (ERR_STICKY != 0) ? err_sticky : (out_valid & head_err);

endmodule

// File: tb/tb_pipe_sel_decoder.sv
// Bench for pipe_sel_decoder: queue-based reference model checked every negedge, plus directed
// vectors with literal expectations; a second instance covers the non-sticky err variant.
module tb_pipe_sel_decoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_sel;
    logic [1:0]  in_mode;
    logic        in_en;
    logic        out_ready;

    logic        in_ready,  in_ready_ns;
    logic        out_valid, out_valid_ns;
    logic [15:0] out_code,  out_code_ns;
    logic [3:0]  out_sel,   out_sel_ns;
    logic        err,       err_ns;

    int checks = 0;
    int fails  = 0;

    pipe_sel_decoder #(.SEL_W(4), .ERR_STICKY(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_mode(in_mode), .in_en(in_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_sel(out_sel), .err(err)
    );

    pipe_sel_decoder #(.SEL_W(4), .ERR_STICKY(0)) dut_ns (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_ns),
        .in_sel(in_sel), .in_mode(in_mode), .in_en(in_en),
        .out_valid(out_valid_ns), .out_ready(out_ready),
        .out_code(out_code_ns), .out_sel(out_sel_ns), .err(err_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] code;
        logic [3:0]  sel;
        logic        e;
    } ent_t;

    ent_t mq[$];
    bit   err_m = 1'b0;

    function automatic logic [15:0] model_code(int sel, int mode, bit en);
        int v;
        case (mode)
            0:       v = en ? (1 << sel) : 0;
            1:       v = en ? ((1 << (sel + 1)) - 1) : 0;
            2:       v = en ? (32'hFFFF ^ (1 << sel)) : 32'hFFFF;
            default: v = 0;
        endcase
        return v[15:0];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            err_m = 1'b0;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && out_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{model_code(int'(in_sel), int'(in_mode), in_en), in_sel, in_mode == 2'b11});
                if (in_mode == 2'b11) err_m = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("m_in_ready",     32'(in_ready),     32'((mq.size() < 2) && !rst));
        check("m_in_ready_ns",  32'(in_ready_ns),  32'((mq.size() < 2) && !rst));
        check("m_out_valid",    32'(out_valid),    32'(mq.size() != 0));
        check("m_out_valid_ns", 32'(out_valid_ns), 32'(mq.size() != 0));
        check("m_err_sticky",   32'(err),          32'(err_m));
        if (mq.size() != 0) begin
            check("m_out_code",    32'(out_code),    32'(mq[0].code));
            check("m_out_code_ns", 32'(out_code_ns), 32'(mq[0].code));
            check("m_out_sel",     32'(out_sel),     32'(mq[0].sel));
            check("m_err_ns",      32'(err_ns),      32'(mq[0].e));
        end else begin
            check("m_err_ns_empty", 32'(err_ns), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] s, logic [1:0] m, logic e);
        in_valid = 1'b1;
        in_sel   = s;
        in_mode  = m;
        in_en    = e;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_mode   = '0;
        in_en     = 1'b1;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code",  32'(out_code),  32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // basic one-hot
        drive(4'hB, 2'b00, 1'b1);
        step();
        in_valid = 1'b0;
        check("t1_code",  32'(out_code), 32'h0800);
        check("t1_sel",   32'(out_sel),  32'hB);
        check("t1_valid", 32'(out_valid), 32'd1);
        step();

        // other modes and enable
        drive(4'h3, 2'b01, 1'b1); step(); in_valid = 1'b0;
        check("t2_thermo3", 32'(out_code), 32'h000F); step();
        drive(4'h0, 2'b10, 1'b1); step(); in_valid = 1'b0;
        check("t2_aloh0", 32'(out_code), 32'hFFFE); step();
        drive(4'h5, 2'b10, 1'b0); step(); in_valid = 1'b0;
        check("t2_aloh_dis", 32'(out_code), 32'hFFFF); step();
        drive(4'h5, 2'b00, 1'b0); step(); in_valid = 1'b0;
        check("t2_oh_dis", 32'(out_code), 32'h0000); step();
        drive(4'hF, 2'b01, 1'b1); step(); in_valid = 1'b0;
        check("t2_thermoF", 32'(out_code), 32'hFFFF); step();
        drive(4'h0, 2'b01, 1'b1); step(); in_valid = 1'b0;
        check("t2_thermo0", 32'(out_code), 32'h0001); step();

        // back-pressure fills the skid buffer
        out_ready = 1'b0;
        drive(4'h1, 2'b00, 1'b1); step();
        check("t3_rdy_after1", 32'(in_ready), 32'd1);
        drive(4'h2, 2'b00, 1'b1); step();
        check("t3_rdy_after2", 32'(in_ready), 32'd0);
        drive(4'h3, 2'b00, 1'b1); step();
        check("t3_hold_code", 32'(out_code), 32'h0002);
        out_ready = 1'b1;
        step();
        check("t3_second", 32'(out_code), 32'h0004);
        step();
        in_valid = 1'b0;
        check("t3_third", 32'(out_code), 32'h0008);
        step();
        check("t3_drained", 32'(out_valid), 32'd0);

        // streaming
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 2'b00, 1'b1);
            check("t4_in_ready", 32'(in_ready), 32'd1);
            step();
            check("t4_code", 32'(out_code), 32'h1 << i);
            check("t4_sel",  32'(out_sel),  32'(i));
        end
        in_valid = 1'b0;
        step();

        // reserved mode and err behaviour
        out_ready = 1'b0;
        drive(4'h5, 2'b11, 1'b1); step(); in_valid = 1'b0;
        check("t5_code",   32'(out_code), 32'h0);
        check("t5_err",    32'(err),      32'd1);
        check("t5_err_ns", 32'(err_ns),   32'd1);
        out_ready = 1'b1;
        step();
        check("t5_err_after_pop",    32'(err),    32'd1);
        check("t5_err_ns_after_pop", 32'(err_ns), 32'd0);
        drive(4'h2, 2'b00, 1'b1); step(); in_valid = 1'b0;
        check("t5_err_still", 32'(err), 32'd1);
        step();

        // async reset with two entries held
        out_ready = 1'b0;
        drive(4'h4, 2'b00, 1'b1); step();
        drive(4'h6, 2'b11, 1'b1); step(); in_valid = 1'b0;
        check("t6_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("t6_valid",  32'(out_valid), 32'd0);
        check("t6_code",   32'(out_code),  32'd0);
        check("t6_err",    32'(err),       32'd0);
        check("t6_err_ns", 32'(err_ns),    32'd0);
        check("t6_rdy",    32'(in_ready),  32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("t6_rdy_rel", 32'(in_ready), 32'd1);
        drive(4'h7, 2'b00, 1'b1); step(); in_valid = 1'b0;
        check("t6_new_valid", 32'(out_valid), 32'd1);
        check("t6_new_code",  32'(out_code),  32'h0080);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
